clkdiv_prog_multi: RTL and testbench
====================================

Name: clkdiv_prog_multi

Overview:
- Parametrised, programmable single-clock divider.
- Generates a divided clock output and a one-cycle period-start strobe from the system clock.
- Supports off, fixed power-of-two, and runtime-programmable integer divide modes.
- Divisor updates are glitch-free: a new value is applied only at a period boundary and acknowledged.
- Serves as the timebase generator feeding the timer-circuit counters.

Parameters:
- DIV_W, 8: width of divisor and period counter.
- STAGES, 4: pow2 mode divides by 2^STAGES; must be < DIV_W.

Ports:
- clk       in   1      system clock; all flops on rising edge.
- arst_n    in   1      asynchronous active-low reset.
- en        in   1      count enable; low freezes divider state.
- mode      in   2      00 off, 01 pow2, 10 programmable, 11 reserved (treated as off).
- div_val   in   DIV_W  requested divisor for mode 10.
- div_load  in   1      one-cycle request to load div_val.
- load_ack  out  1      one-cycle pulse when the loaded divisor takes effect.
- clk_out   out  1      divided clock, registered.
- tick      out  1      one-cycle strobe at start of each output period, registered.

Behaviour:
- Reset (arst_n low, async):
  - active divisor A=2, pending flag=0, cnt=1, mode_q=00.
  - clk_out=0, tick=0, load_ack=0.
- Effective period N:
  - mode 01: 2^STAGES.
  - mode 10: A, with A<2 (0 or 1) treated as 2.
- Counting, when mode is 01/10, en=1 and no mode change this cycle:
  - cnt <= (cnt==N-1) ? 0 : cnt+1.
- Registered outputs; value in the cycle where cnt==k:
  - clk_out = (k < N>>1); high floor(N/2) cycles, low ceil(N/2) cycles per period.
  - tick = (k==0) and the cycle was reached by a wrap; tick rises with clk_out.
- en=0: cnt and clk_out hold; tick=0; load_ack=0.
- Off modes (00/11): cnt <= N-1, where N is evaluated as for mode 10. clk_out=0, tick=0. Pending loads are still captured.
- Divisor load:
  - When div_load=1, pending_val <= div_val and pending <= 1.
  - A second div_load before application overwrites pending_val; only one load_ack results.
  - Application happens on the enabled wrap cycle (cnt==N-1 -> 0) with pending=1: A <= pending_val and pending <= 0. The new period starting at cnt==0 uses the new N, and load_ack=1 in that cycle, coincident with tick.
  - div_load in the same cycle as a wrap: the old pending value, if any, is applied. The new value becomes pending for the next wrap.
  - In mode 01, loads update A at wraps in the same way but do not change N.
- Mode change (mode != mode_q): mode_q <= mode, cnt <= N_new-1, clk_out <= 0, tick <= 0. If pending=1, A <= pending_val and load_ack pulses at the first tick of the new mode. The first enabled cycle after that starts a period (tick=1).
- Reset mid-period: all state returns to reset values immediately. Any pending load is discarded.
- Arithmetic: cnt is DIV_W bits wide and never exceeds N-1. A divisor of 2^DIV_W-1 must work without overflow.

Test Plan:
- Reset -> mode=10, div_val=5, div_load pulse, en=1 -> first period is /2 (tick every 2 cycles). The next period is /5: clk_out high 2 cycles, low 3. load_ack coincides with the first /5 tick.
- mode=01, STAGES=4, en=1 for 64 cycles -> tick every 16 cycles (4 ticks). clk_out is a 50% square wave, 8 high and 8 low.
- mode=10, div_val=4 active, assert div_load with 7 then 9 mid-period -> single load_ack at next wrap; subsequent period is 9 cycles (4 high, 5 low).
- div_val=0 and div_val=1 loaded -> behaves as /2. div_val=255 -> 127 high, 128 low, no counter overflow.
- en toggled low for 3 cycles mid-period at cnt=2 of /6 -> clk_out and cnt frozen, no tick. The period resumes and total period length is 9 cycles.
- arst_n asserted mid-period with pending load -> clk_out, tick and load_ack are 0 immediately. After release, divide-by-2 operation resumes and no load_ack appears.

Source files
------------

// File: rtl/clkdiv_prog_multi.sv
// Programmable clock divider: off, fixed 2^STAGES, or runtime integer divide.
// Divisor changes are deferred to a period boundary and acknowledged with load_ack.
module clkdiv_prog_multi #(
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  output logic             load_ack,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [1:0]       ModePow2 = 2'b01;
  localparam logic [1:0]       ModeProg = 2'b10;
  localparam logic [DIV_W-1:0] One      = DIV_W'(1);
  localparam logic [DIV_W-1:0] Two      = DIV_W'(2);

  // Period length for a given mode and divisor; off/reserved modes use the prog rule.
  function automatic logic [DIV_W-1:0] period_of(input logic [1:0] m, input logic [DIV_W-1:0] a);
    if (m == ModePow2) begin
      return One << STAGES;
    end else if (a < Two) begin
      return Two;
    end else begin
      return a;
    end
  endfunction

  logic [DIV_W-1:0] a_q, a_d;
  logic [DIV_W-1:0] pend_val_q, pend_val_d;
  logic             pending_q, pending_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  // Set when a mode change consumed a pending load; the ack waits for the first tick.
  logic             arm_q, arm_d;

  logic [DIV_W-1:0] n_cur;
  logic [DIV_W-1:0] a_next;
  logic [DIV_W-1:0] cnt_inc;
  logic             active;

  always_comb begin
    a_d        = a_q;
    pend_val_d = pend_val_q;
    pending_d  = pending_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    clk_out_d  = clk_out_q;
    tick_d     = 1'b0;
    ack_d      = 1'b0;
    arm_d      = arm_q;
    a_next     = a_q;

    n_cur   = period_of(mode_q, a_q);
    cnt_inc = cnt_q + One;
    active  = (mode_q == ModePow2) || (mode_q == ModeProg);

    if (mode != mode_q) begin
      mode_d = mode;
      if (pending_q) begin
        a_next    = pend_val_q;
        pending_d = 1'b0;
        arm_d     = 1'b1;
      end
      a_d       = a_next;
      cnt_d     = period_of(mode, a_next) - One;
      clk_out_d = 1'b0;
    end else if (!active) begin
      cnt_d     = n_cur - One;
      clk_out_d = 1'b0;
    end else if (en) begin
      if (cnt_q == n_cur - One) begin
        // Period start: N >= 2, so clk_out is always high at cnt==0.
        cnt_d     = '0;
        tick_d    = 1'b1;
        clk_out_d = 1'b1;
        if (pending_q) begin
          a_d       = pend_val_q;
          pending_d = 1'b0;
          ack_d     = 1'b1;
        end
        if (arm_q) begin
          ack_d = 1'b1;
          arm_d = 1'b0;
        end
      end else begin
        cnt_d     = cnt_inc;
        clk_out_d = cnt_inc < (n_cur >> 1);
      end
    end

    // Captured after any application so a load on a wrap stays pending for the next one.
    if (div_load) begin
      pend_val_d = div_val;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      a_q        <= Two;
      pend_val_q <= '0;
      pending_q  <= 1'b0;
      cnt_q      <= One;
      mode_q     <= 2'b00;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      ack_q      <= 1'b0;
      arm_q      <= 1'b0;
    end else begin
      a_q        <= a_d;
      pend_val_q <= pend_val_d;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      ack_q      <= ack_d;
      arm_q      <= arm_d;
    end
  end

  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
  assign load_ack = ack_q;

endmodule

// File: tb/tb_clkdiv_prog_multi.sv
// Directed bench for clkdiv_prog_multi: checks clk_out/tick/load_ack every cycle
// against hand-derived period shapes.
module tb_clkdiv_prog_multi;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       en;
  logic [1:0] mode;
  logic [7:0] div_val;
  logic       div_load;
  logic       load_ack;
  logic       clk_out;
  logic       tick;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  clkdiv_prog_multi #(
    .DIV_W (8),
    .STAGES(4)
  ) dut (
    .clk     (clk),
    .arst_n  (arst_n),
    .en      (en),
    .mode    (mode),
    .div_val (div_val),
    .div_load(div_load),
    .load_ack(load_ack),
    .clk_out (clk_out),
    .tick    (tick)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // One clock, then sample outputs on the falling edge.
  task automatic cyc(input string tag, input logic e_clk, input logic e_tick, input logic e_ack);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".clk_out"}, clk_out, e_clk);
    chk({tag, ".tick"}, tick, e_tick);
    chk({tag, ".load_ack"}, load_ack, e_ack);
  endtask

  // One full output period of length n; div_load is dropped after its first cycle.
  task automatic period(input string tag, input int n, input bit ack_first);
    for (int k = 0; k < n; k++) begin
      cyc(tag, logic'(k < n / 2), logic'(k == 0), logic'(ack_first && (k == 0)));
      div_load = 1'b0;
    end
  endtask

  initial begin
    arst_n   = 1'b0;
    en       = 1'b1;
    mode     = 2'b10;
    div_val  = 8'd0;
    div_load = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.clk_out", clk_out, 1'b0);
    chk("reset.tick", tick, 1'b0);
    chk("reset.load_ack", load_ack, 1'b0);

    // First period /2, then the loaded /5 with ack on its first tick.
    arst_n = 1'b1;
    cyc("t1.modechg", 1'b0, 1'b0, 1'b0);
    div_load = 1'b1;
    div_val  = 8'd5;
    period("t1.div2", 2, 1'b0);
    period("t1.div5a", 5, 1'b1);
    period("t1.div5b", 5, 1'b0);

    // Fixed pow2 mode: 16-cycle periods, 8 high / 8 low.
    mode = 2'b01;
    cyc("t2.modechg", 1'b0, 1'b0, 1'b0);
    repeat (4) period("t2.pow2", 16, 1'b0);

    // Back to prog with A=5; a load of 4 applies at the first wrap.
    mode     = 2'b10;
    div_load = 1'b1;
    div_val  = 8'd4;
    cyc("t3.modechg", 1'b0, 1'b0, 1'b0);
    div_load = 1'b0;
    period("t3.div4a", 4, 1'b1);
    // Two loads (7 then 9) in one period: only 9 applies, one ack.
    div_load = 1'b1;
    div_val  = 8'd7;
    cyc("t3.k0", 1'b1, 1'b1, 1'b0);
    div_val = 8'd9;
    cyc("t3.k1", 1'b1, 1'b0, 1'b0);
    div_load = 1'b0;
    cyc("t3.k2", 1'b0, 1'b0, 1'b0);
    cyc("t3.k3", 1'b0, 1'b0, 1'b0);
    period("t3.div9a", 9, 1'b1);
    period("t3.div9b", 9, 1'b0);

    // Divisors 0 and 1 act as /2; 255 runs without overflow.
    div_load = 1'b1;
    div_val  = 8'd0;
    period("t4.div9", 9, 1'b0);
    period("t4.d0a", 2, 1'b1);
    period("t4.d0b", 2, 1'b0);
    div_load = 1'b1;
    div_val  = 8'd1;
    period("t4.d0c", 2, 1'b0);
    period("t4.d1", 2, 1'b1);
    div_load = 1'b1;
    div_val  = 8'd255;
    period("t4.d1b", 2, 1'b0);
    period("t4.d255a", 255, 1'b1);
    period("t4.d255b", 255, 1'b0);

    // /6 frozen for 3 cycles at cnt=2: 9-cycle period, no extra tick.
    div_load = 1'b1;
    div_val  = 8'd6;
    period("t5.d255", 255, 1'b0);
    period("t5.div6", 6, 1'b1);
    cyc("t5.k0", 1'b1, 1'b1, 1'b0);
    cyc("t5.k1", 1'b1, 1'b0, 1'b0);
    cyc("t5.k2", 1'b1, 1'b0, 1'b0);
    en = 1'b0;
    repeat (3) cyc("t5.hold", 1'b1, 1'b0, 1'b0);
    en = 1'b1;
    cyc("t5.k3", 1'b0, 1'b0, 1'b0);
    cyc("t5.k4", 1'b0, 1'b0, 1'b0);
    cyc("t5.k5", 1'b0, 1'b0, 1'b0);
    div_load = 1'b1;
    div_val  = 8'd3;
    cyc("t5.next", 1'b1, 1'b1, 1'b0);
    div_load = 1'b0;

    // Async reset while tick/clk_out are high and a load is pending.
    arst_n = 1'b0;
    #1;
    chk("t6.rst.clk_out", clk_out, 1'b0);
    chk("t6.rst.tick", tick, 1'b0);
    chk("t6.rst.load_ack", load_ack, 1'b0);
    @(negedge clk);
    arst_n = 1'b1;
    cyc("t6.modechg", 1'b0, 1'b0, 1'b0);
    repeat (3) period("t6.div2", 2, 1'b0);

    // Reserved mode behaves as off.
    mode = 2'b11;
    repeat (3) cyc("t7.off", 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
